// File: rtl/accum_seg_d1.sv
// Segment accumulator: sums data tokens until an end-of-segment token, then emits
// the wrapped sum (with overflow sideband) followed by an end-of-segment token.
module accum_seg_d1 #(
    parameter int unsigned W = 8,
    parameter int unsigned G = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [W-1:0]     in_d,
    input  logic             in_e,
    input  logic             in_v,
    output logic             in_b,
    output logic [W+G-1:0]   out_d,
    output logic             out_e,
    output logic             out_v,
    input  logic             out_b,
    output logic             out_ovf
);

    localparam int unsigned OW = W + G;
    localparam int unsigned SW = OW + 1;

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_SUM = 2'd1,
        ST_EOS = 2'd2
    } state_t;

    state_t        state;
    logic [OW-1:0] acc;
    logic          ovf;
    logic [SW-1:0] sum_c;
    logic          in_xfer_c;

    // in_b is a register, so the transfer qualifier has no input-to-in_b path
    assign in_xfer_c = in_v && !in_b;
    assign sum_c     = SW'(acc) + SW'(in_d);

    // in_b resets high and clears on the first edge after reset release
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_ACC;
            acc     <= '0;
            ovf     <= 1'b0;
            out_d   <= '0;
            out_e   <= 1'b0;
            out_v   <= 1'b0;
            out_ovf <= 1'b0;
            in_b    <= 1'b1;
        end else begin
            case (state)
                ST_ACC: begin
                    in_b <= 1'b0;
                    if (in_xfer_c) begin
                        if (in_e) begin
                            state   <= ST_SUM;
                            out_d   <= acc;
                            out_e   <= 1'b0;
                            out_ovf <= ovf;
                            out_v   <= 1'b1;
                            in_b    <= 1'b1;
                        end else begin
                            acc <= sum_c[OW-1:0];
                            ovf <= ovf | sum_c[OW];
                        end
                    end
                end
                ST_SUM: begin
                    if (!out_b) begin
                        state   <= ST_EOS;
                        out_d   <= '0;
                        out_e   <= 1'b1;
                        out_ovf <= 1'b0;
                        out_v   <= 1'b1;
                        acc     <= '0;
                        ovf     <= 1'b0;
                    end
                end
                ST_EOS: begin
                    if (!out_b) begin
                        state <= ST_ACC;
                        out_v <= 1'b0;
                        out_e <= 1'b0;
                        in_b  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_ACC;
                    in_b  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accum_seg_d1.sv
// Bench for accum_seg_d1: directed cycle table, hand-written corner sequences,
// and a randomized run scored against a segment-sum reference model.
module tb_accum_seg_d1;

    localparam int unsigned W  = 8;
    localparam int unsigned G  = 4;
    localparam int unsigned OW = W + G;

    logic          clock = 1'b0;
    logic          reset;
    logic [W-1:0]  in_d;
    logic          in_e;
    logic          in_v;
    logic          in_b;
    logic [OW-1:0] out_d;
    logic          out_e;
    logic          out_v;
    logic          out_b;
    logic          out_ovf;

    int n_vec = 0;
    int n_bad = 0;

    accum_seg_d1 #(.W(W), .G(G)) dut (
        .clock   (clock),
        .reset   (reset),
        .in_d    (in_d),
        .in_e    (in_e),
        .in_v    (in_v),
        .in_b    (in_b),
        .out_d   (out_d),
        .out_e   (out_e),
        .out_v   (out_v),
        .out_b   (out_b),
        .out_ovf (out_ovf)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          v;
        logic          e;
        logic [W-1:0]  d;
        logic          ob;
        logic          ib;
        logic          ov;
        logic          oe;
        logic [OW-1:0] od;
        logic          oo;
    } vec_t;

    vec_t tbl[$];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chkd(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ib, input logic ov, input logic oe,
                           input logic [OW-1:0] od, input logic oo);
        chk1({tag, "_in_b"}, in_b, ib);
        chk1({tag, "_out_v"}, out_v, ov);
        chk1({tag, "_out_e"}, out_e, oe);
        chkd({tag, "_out_d"}, out_d, od);
        chk1({tag, "_out_ovf"}, out_ovf, oo);
    endtask

    function automatic vec_t mk(input logic v, input logic e, input logic [W-1:0] d, input logic ob,
                                input logic ib, input logic ov, input logic oe,
                                input logic [OW-1:0] od, input logic oo);
        vec_t r;
        r.v = v; r.e = e; r.d = d; r.ob = ob;
        r.ib = ib; r.ov = ov; r.oe = oe; r.od = od; r.oo = oo;
        return r;
    endfunction

    // Present one token at a negedge and wait until it is accepted.
    task automatic send_tok(input string tag, input logic e, input logic [W-1:0] d);
        bit ok;
        ok   = 1'b0;
        in_v = 1'b1;
        in_e = e;
        in_d = d;
        for (int k = 0; k < 20; k++) begin
            if (in_b === 1'b0) begin
                @(negedge clock);
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        in_v = 1'b0;
        in_e = 1'b0;
        if (!ok) chk1({tag, "_accept_timeout"}, 1'b0, 1'b1);
    endtask

    // Random-phase scoreboard storage
    logic [W-1:0]  tok_d[$];
    logic          tok_e[$];
    logic [OW-1:0] exp_d[$];
    logic          exp_e[$];
    logic          exp_o[$];

    initial begin
        reset = 1'b0;
        in_d  = '0;
        in_e  = 1'b0;
        in_v  = 1'b0;
        out_b = 1'b0;
        repeat (3) @(negedge clock);
        chk_out("reset", 1'b1, 1'b0, 1'b0, '0, 1'b0);
        reset = 1'b1;

        // Cycle table: inputs applied at a negedge, outputs expected after the next edge
        tbl.push_back(mk(0, 0, 8'd0,  0, 0, 0, 0, 12'd0,  0));
        tbl.push_back(mk(1, 0, 8'd3,  0, 0, 0, 0, 12'd0,  0));
        tbl.push_back(mk(1, 0, 8'd5,  0, 0, 0, 0, 12'd0,  0));
        tbl.push_back(mk(1, 0, 8'd7,  0, 0, 0, 0, 12'd0,  0));
        tbl.push_back(mk(1, 1, 8'd0,  0, 1, 1, 0, 12'd15, 0));
        tbl.push_back(mk(0, 0, 8'd0,  0, 1, 1, 1, 12'd0,  0));
        tbl.push_back(mk(0, 0, 8'd0,  0, 0, 0, 0, 12'd0,  0));
        tbl.push_back(mk(1, 1, 8'd0,  0, 1, 1, 0, 12'd0,  0));
        tbl.push_back(mk(1, 1, 8'd0,  0, 1, 1, 1, 12'd0,  0));
        tbl.push_back(mk(1, 1, 8'd0,  0, 0, 0, 0, 12'd0,  0));
        tbl.push_back(mk(1, 1, 8'd0,  0, 1, 1, 0, 12'd0,  0));
        tbl.push_back(mk(0, 0, 8'd0,  0, 1, 1, 1, 12'd0,  0));
        tbl.push_back(mk(0, 0, 8'd0,  0, 0, 0, 0, 12'd0,  0));
        tbl.push_back(mk(1, 0, 8'd10, 0, 0, 0, 0, 12'd0,  0));
        tbl.push_back(mk(1, 1, 8'd0,  0, 1, 1, 0, 12'd10, 0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(1, 0, 8'd99, 1, 1, 1, 0, 12'd10, 0));
        tbl.push_back(mk(1, 0, 8'd99, 0, 1, 1, 1, 12'd0,  0));
        tbl.push_back(mk(0, 0, 8'd0,  0, 0, 0, 0, 12'd0,  0));
        tbl.push_back(mk(1, 0, 8'd1,  0, 0, 0, 0, 12'd0,  0));
        tbl.push_back(mk(1, 1, 8'd0,  0, 1, 1, 0, 12'd1,  0));
        tbl.push_back(mk(0, 0, 8'd0,  0, 1, 1, 1, 12'd0,  0));
        tbl.push_back(mk(0, 0, 8'd0,  0, 0, 0, 0, 12'd0,  0));

        foreach (tbl[i]) begin
            in_v  = tbl[i].v;
            in_e  = tbl[i].e;
            in_d  = tbl[i].d;
            out_b = tbl[i].ob;
            @(negedge clock);
            chk_out($sformatf("row%0d", i), tbl[i].ib, tbl[i].ov, tbl[i].oe, tbl[i].od, tbl[i].oo);
        end
        in_v  = 1'b0;
        out_b = 1'b0;

        // Wrap: 17 x 255 = 4335 -> 239 with overflow, then a clean segment
        for (int k = 0; k < 17; k++) send_tok("wrap", 1'b0, 8'd255);
        send_tok("wrap", 1'b1, 8'd0);
        chk_out("wrap_sum", 1'b1, 1'b1, 1'b0, 12'd239, 1'b1);
        @(negedge clock);
        chk_out("wrap_eos", 1'b1, 1'b1, 1'b1, 12'd0, 1'b0);
        @(negedge clock);
        send_tok("after_wrap", 1'b0, 8'd1);
        send_tok("after_wrap", 1'b1, 8'd0);
        chk_out("after_wrap_sum", 1'b1, 1'b1, 1'b0, 12'd1, 1'b0);
        repeat (2) @(negedge clock);

        // Reset mid-segment discards the partial sum
        send_tok("rst_seg", 1'b0, 8'd4);
        send_tok("rst_seg", 1'b0, 8'd4);
        reset = 1'b0;
        #1;
        chk_out("rst_seg_async", 1'b1, 1'b0, 1'b0, 12'd0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        send_tok("rst_seg", 1'b0, 8'd2);
        send_tok("rst_seg", 1'b1, 8'd0);
        chk_out("rst_seg_sum", 1'b1, 1'b1, 1'b0, 12'd2, 1'b0);
        repeat (2) @(negedge clock);

        // Reset while a sum token is pending drops it at once, no token afterwards
        send_tok("rst_emit", 1'b0, 8'd9);
        send_tok("rst_emit", 1'b1, 8'd0);
        chk_out("rst_emit_pre", 1'b1, 1'b1, 1'b0, 12'd9, 1'b0);
        reset = 1'b0;
        #1;
        chk_out("rst_emit_async", 1'b1, 1'b0, 1'b0, 12'd0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk_out("rst_emit_after", 1'b0, 1'b0, 1'b0, 12'd0, 1'b0);

        // Randomized segments vs. reference sums
        for (int s = 0; s < 1000; s++) begin
            int len;
            int total;
            logic [W-1:0] dv;
            len   = $urandom_range(0, 20);
            total = 0;
            for (int j = 0; j < len; j++) begin
                dv = ($urandom_range(0, 3) == 0) ? 8'd255 : W'($urandom_range(0, 255));
                tok_d.push_back(dv);
                tok_e.push_back(1'b0);
                total += int'(dv);
            end
            tok_d.push_back(W'($urandom_range(0, 255)));
            tok_e.push_back(1'b1);
            exp_d.push_back(OW'(total % 4096));
            exp_e.push_back(1'b0);
            exp_o.push_back(total >= 4096);
            exp_d.push_back('0);
            exp_e.push_back(1'b1);
            exp_o.push_back(1'b0);
        end

        begin
            int cyc;
            bit hold;
            logic [OW-1:0] pd;
            logic pe, po;
            cyc = 0;
            while (exp_d.size() > 0 && cyc < 60000) begin
                in_v = (tok_e.size() > 0) && ($urandom_range(0, 3) != 0);
                if (tok_e.size() > 0) begin
                    in_e = tok_e[0];
                    in_d = tok_d[0];
                end
                out_b = ($urandom_range(0, 2) == 0);
                if (out_v && !out_b) begin
                    chkd("rand_out_d", out_d, exp_d[0]);
                    chk1("rand_out_e", out_e, exp_e[0]);
                    chk1("rand_out_ovf", out_ovf, exp_o[0]);
                    void'(exp_d.pop_front());
                    void'(exp_e.pop_front());
                    void'(exp_o.pop_front());
                end
                hold = out_v && out_b;
                pd = out_d;
                pe = out_e;
                po = out_ovf;
                if (in_v && !in_b) begin
                    void'(tok_d.pop_front());
                    void'(tok_e.pop_front());
                end
                @(negedge clock);
                cyc++;
                if (hold) begin
                    chk1("rand_stall_v", out_v, 1'b1);
                    chkd("rand_stall_d", out_d, pd);
                    chk1("rand_stall_e", out_e, pe);
                    chk1("rand_stall_ovf", out_ovf, po);
                end
            end
            in_v  = 1'b0;
            out_b = 1'b0;
            chkd("rand_pending_outputs", OW'(exp_d.size()), '0);
            chkd("rand_pending_inputs", OW'(tok_e.size()), '0);
            repeat (3) @(negedge clock);
            chk1("rand_no_extra_token", out_v, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
